alu_rr_arbiter: RTL
===================

Name: alu_rr_arbiter

Overview:
- Shares the single combinational 32-bit ALU slice-chain between NREQ independent requesters (e.g. execute stage, address generator, debug port).
- Grants one operation per cycle in round-robin order, drives the ALU operand and function inputs, and captures dataOut into a registered result buffer with requester ID.
- Valid/ready handshake on both sides, so requesters and the result consumer may stall independently.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester ID width; must equal clog2(NREQ), minimum 1.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  NREQ  requester i has an operation pending
- req_ready  out  NREQ  one-hot grant; the operation is consumed when req_valid[i] & req_ready[i]
- req_dataA  in  NREQ*32  operand A, requester i at bits [32i+31:32i]
- req_dataB  in  NREQ*32  operand B, same packing
- req_signal  in  NREQ*6  function code, requester i at [6i+5:6i]
- alu_dataA  out  32  to ALU dataA
- alu_dataB  out  32  to ALU dataB
- alu_Signal  out  6  to ALU Signal
- alu_reset  out  1  to ALU reset; equals reset
- alu_dataOut  in  32  from ALU dataOut
- res_valid  out  1  result buffer full
- res_ready  in  1  consumer accepts result
- res_data  out  32  result
- res_id  out  IDW  index of the requester that issued the result
- res_err  out  1  function code was not legal
- op_count  out  32  number of operations granted since reset

Behaviour:
- Legal function codes: ADD 6'd32, SUB 6'd34, AND 6'd36, OR 6'd37, SLT 6'd42. Any other code is accepted and completes with res_err=1 and res_data=0.
- Issue slot is free when res_valid==0, or when res_valid & res_ready (same-cycle drain and refill).
- Arbitration is combinational:
  - prio pointer p (IDW bits).
  - Scan order is p, p+1, ..., wrapping modulo NREQ.
  - The first i with req_valid[i] wins. req_ready[i]=1 only for the winner, and only when the slot is free.
  - req_ready has no other dependence on req_valid, and never depends on any other requester's data.
- ALU drive:
  - alu_dataA, alu_dataB and alu_Signal are muxed from the winner.
  - With no winner they are driven to 0 (Signal 0 is not used as a valid ALU op; output is ignored).
- On a grant (rising edge):
  - res_data <= legal ? alu_dataOut : 0.
  - res_id <= winner; res_err <= !legal; res_valid <= 1.
  - p <= winner+1 modulo NREQ; op_count <= op_count+1, wrapping 2^32-1 -> 0.
- Latency: grant cycle N gives res_valid at cycle N+1. Sustained throughput is 1 operation per cycle while res_ready=1.
- Drain without refill: res_valid & res_ready with no grant sets res_valid <= 0. res_data, res_id and res_err hold their last values.
- Stall: res_valid & !res_ready means all req_ready=0. The result registers and p hold.
- p does not advance when there is no grant.
- Reset (any cycle, including mid-stall):
  - res_valid=0, res_data=0, res_id=0, res_err=0, p=0, op_count=0.
  - The pending result is discarded.
  - Since alu_reset=reset, the ALU output is 0 during reset.
  - req_ready=0 while reset=1.
- Requesters must hold operands stable while req_valid=1 and not granted. The arbiter does not check this.

Decomposition:
- Shared package alu_pkg:
  - Function-code constants ADD, SUB, AND, OR, SLT (same values the ALU uses).
  - A legal-code function.
  - Data width 32.
- Sub-module rr_pick: NREQ-wide round-robin priority picker (inputs valid vector and p; outputs one-hot grant, binary index, any). The top level holds p, the result buffer and the counter.

Test Plan:
- Single request: req0 ADD A=5 B=7, res_ready=1 -> next cycle res_valid=1, res_data=12, res_id=0, res_err=0, op_count=1.
- All 4 requesters valid continuously with SUB 10-3, res_ready=1 -> grants 0,1,2,3,0,... one per cycle; each res_data=7; res_id sequence 0,1,2,3,0.
- SLT A=0xFFFFFFFF (-1) B=1 -> res_data=1. Then SLT A=1 B=0xFFFFFFFF -> res_data=0.
- Back-pressure: res_ready=0 for 3 cycles with req1 valid -> req_ready stays 0, res_data holds. Then res_ready=1 -> req1 is granted in the same cycle the old result drains, with no bubble.
- Illegal code 6'd0 from req2 -> res_err=1, res_data=0, res_id=2. A following OR 0xF0|0x0F -> res_data=0xFF, res_err=0.
- Reset asserted while res_valid=1 and stalled -> next cycle res_valid=0, op_count=0, p=0. After release, with all requesters valid, req0 wins first.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: data width, function codes and legality check.
package alu_pkg;

    localparam int DW = 32;
    localparam int FW = 6;

    localparam logic [FW-1:0] ADD = 6'd32;
    localparam logic [FW-1:0] SUB = 6'd34;
    localparam logic [FW-1:0] AND = 6'd36;
    localparam logic [FW-1:0] OR  = 6'd37;
    localparam logic [FW-1:0] SLT = 6'd42;

    function automatic logic is_legal(input logic [FW-1:0] fn);
        logic ok;
        ok = 1'b0;
        case (fn)
            ADD, SUB, AND, OR, SLT: ok = 1'b1;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/alu_rr_arbiter_rr_pick.sv
// Round-robin priority picker: scans from p upward, wrapping modulo NREQ.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  p,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = int'(p) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!any && valid[j]) begin
                any    = 1'b1;
                idx    = j[IDW-1:0];
                gnt[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NREQ requesters,
// with a one-entry registered result buffer tagged by requester ID.
module alu_rr_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*DW-1:0] req_dataA,
    input  logic [NREQ*DW-1:0] req_dataB,
    input  logic [NREQ*FW-1:0] req_signal,
    output logic [DW-1:0]      alu_dataA,
    output logic [DW-1:0]      alu_dataB,
    output logic [FW-1:0]      alu_Signal,
    output logic               alu_reset,
    input  logic [DW-1:0]      alu_dataOut,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [DW-1:0]      res_data,
    output logic [IDW-1:0]     res_id,
    output logic               res_err,
    output logic [31:0]        op_count
);

    logic [IDW-1:0]  p;
    logic [IDW-1:0]  p_nxt;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  win;
    logic            any;
    logic            slot_free;
    logic            grant;
    logic            legal;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .valid (req_valid),
        .p     (p),
        .gnt   (gnt),
        .idx   (win),
        .any   (any)
    );

    assign alu_reset = reset;
    assign slot_free = !res_valid || res_ready;
    assign grant     = any && slot_free && !reset;
    assign req_ready = grant ? gnt : '0;
    assign legal     = is_legal(alu_Signal);

    always_comb begin
        alu_dataA  = '0;
        alu_dataB  = '0;
        alu_Signal = '0;
        if (any) begin
            alu_dataA  = req_dataA[int'(win)*DW +: DW];
            alu_dataB  = req_dataB[int'(win)*DW +: DW];
            alu_Signal = req_signal[int'(win)*FW +: FW];
        end
    end

    // Pointer moves to the slot after the winner, wrapping at NREQ.
    always_comb begin
        if (win == IDW'(NREQ - 1)) p_nxt = '0;
        else                       p_nxt = win + IDW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= '0;
            res_err   <= 1'b0;
            p         <= '0;
            op_count  <= '0;
        end else if (grant) begin
            res_valid <= 1'b1;
            res_data  <= legal ? alu_dataOut : '0;
            res_id    <= win;
            res_err   <= !legal;
            p         <= p_nxt;
            op_count  <= op_count + 32'd1;
        end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule
